summer_uart_tx: RTL and testbench

//  Byte-serial UART transmitter with a small input FIFO. It drives one uo_out pin of
//  tt_um_SummerTT_HDL so the bench or host can receive the design's results as 8N1 frames.

---
 rtl/summer_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_summer_uart_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/summer_uart_tx.sv
// summer_uart_tx: byte-serial UART transmitter with a small input FIFO.
// Frames are 8N1 by default; define SUMMER_UART_PARITY_EN for 8E1 frames
// (even parity bit between the last data bit and the stop bit).
`timescale 1ns/1ps
module summer_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic [7:0]                      tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              tx_q, tx_nxt;
  logic              full, empty, push, pop, baud_wrap;
`ifdef SUMMER_UART_PARITY_EN
  logic              parity_q;
`endif

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // Gated by rst_n so the handshake is closed while reset is held.
  assign tx_ready   = rst_n & ena & ~full;
  assign push       = tx_valid & tx_ready;
  assign baud_wrap  = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx         = tx_q;
  assign busy       = (state != S_IDLE) | ~empty;
  assign fifo_count = count;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, FIFO pop and next line level; tx is computed one edge ahead so it is registered.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = tx_q;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (ena && !empty) begin
          pop       = 1'b1;
          tx_nxt    = 1'b0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          tx_nxt    = shreg[0];
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_idx == 3'd7) begin
`ifdef SUMMER_UART_PARITY_EN
            tx_nxt    = parity_q;
            state_nxt = S_PARITY;
`else
            tx_nxt    = 1'b1;
            state_nxt = S_STOP;
`endif
          end else begin
            // shreg[0] is the bit on the line now; shreg[1] is the next one.
            tx_nxt = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          tx_nxt    = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (ena && !empty) begin
            pop       = 1'b1;
            tx_nxt    = 1'b0;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Line register, baud counter and bit index; the line idles high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q    <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      tx_q <= tx_nxt;
      if (state == S_IDLE || baud_wrap) baud <= '0;
      else                              baud <= baud + 1'b1;
      if (state == S_START && baud_wrap)     bit_idx <= '0;
      else if (state == S_DATA && baud_wrap) bit_idx <= bit_idx + 1'b1;
    end
  end

  // Shift register: loaded on pop, shifted right at each data bit boundary.
  always_ff @(posedge clk) begin
    if (pop)                               shreg <= mem[rd_ptr];
    else if (state == S_DATA && baud_wrap) shreg <= {1'b0, shreg[7:1]};
  end

`ifdef SUMMER_UART_PARITY_EN
  // Even parity of the byte, captured alongside the shift register load.
  always_ff @(posedge clk) begin
    if (pop) parity_q <= ^mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_summer_uart_tx.sv
// tb_summer_uart_tx: directed bench for summer_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Honors SUMMER_UART_PARITY_EN to select the 8E1 expectations.
`timescale 1ns/1ps
module tb_summer_uart_tx;

  localparam int CPB = 4;
`ifdef SUMMER_UART_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] F_A5 = 11'b10101001010;
  localparam logic [10:0] F_01 = 11'b11000000010;
  localparam logic [10:0] F_FF = 11'b10111111110;
`else
  localparam int NB = 10;
  localparam logic [10:0] F_A5 = 11'b11101001010;
  localparam logic [10:0] F_01 = 11'b11000000010;
  localparam logic [10:0] F_FF = 11'b11111111110;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ena, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx, busy;
  logic [2:0] fifo_count;
  int         checks = 0;
  int         errors = 0;

  summer_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level for each bit time of a frame carrying d (bit 0 = start bit).
  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef SUMMER_UART_PARITY_EN
    f[9]   = ^d;
`else
    f[9]   = 1'b1;
`endif
    f[10]  = 1'b1;
    return f;
  endfunction

  // Checks tx for frame samples k0..k1-1, one per cycle, sampled on the falling edge.
  task automatic check_bits(input logic [10:0] fr, input int k0, input int k1, input string tag);
    for (int k = k0; k < k1; k++) begin
      chk(tag, tx, fr[k/CPB]);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ready", tx_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", tx_ready, 1'b1);

    // 1: single byte 0xA5
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("t1_count", fifo_count, 3'd1);
    chk("t1_tx_pre", tx, 1'b1);
    chk("t1_busy_pre", busy, 1'b1);
    @(negedge clk);
    check_bits(F_A5, 0, NB*CPB-1, "t1_frame");
    chk("t1_busy_last", busy, 1'b1);
    @(negedge clk);
    chk("t1_busy_fall", busy, 1'b0);
    chk("t1_tx_idle", tx, 1'b1);

    // 2: tx_valid held 6 cycles, 5 accepted, ready returns on STOP->START pop
    for (int i = 0; i < 6; i++) begin
      tx_data  = 8'h10 + 8'(i);
      tx_valid = 1'b1;
      chk("t2_ready", tx_ready, (i < 5) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("t2_count_full", fifo_count, 3'd4);
    repeat (NB*CPB - 1 - 4) @(negedge clk);
    chk("t2_ready_stop", tx_ready, 1'b0);
    chk("t2_count_stop", fifo_count, 3'd4);
    chk("t2_tx_stop", tx, 1'b1);
    @(negedge clk);
    chk("t2_ready_pop", tx_ready, 1'b1);
    chk("t2_count_pop", fifo_count, 3'd3);
    check_bits(mk_frame(8'h11), 0, NB*CPB, "t2_frame2");
    wait_idle(4*NB*CPB, "t2_drain");
    chk("t2_count_end", fifo_count, 3'd0);

    // 3: 0x01 then 0xFF back-to-back
    tx_valid = 1'b1; tx_data = 8'h01;
    @(negedge clk);
    tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("t3_count", fifo_count, 3'd1);
    check_bits(F_01, 0, NB*CPB, "t3_frame01");
    check_bits(F_FF, 0, NB*CPB, "t3_frameFF");
    chk("t3_busy_end", busy, 1'b0);

    // 4: reset during the third data bit with two bytes queued
    tx_valid = 1'b1; tx_data = 8'h5A;
    @(negedge clk);
    tx_data = 8'hC3;
    @(negedge clk);
    tx_data = 8'h3C;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("t4_tx_bit2", tx, 1'b0);
    chk("t4_count_pre", fifo_count, 3'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_tx_rst", tx, 1'b1);
    chk("t4_count_rst", fifo_count, 3'd0);
    chk("t4_busy_rst", busy, 1'b0);
    chk("t4_ready_rst", tx_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t4_idle_tx", tx, 1'b1);
    end
    chk("t4_idle_busy", busy, 1'b0);

    // 5: ena dropped mid-frame with one byte queued
    tx_valid = 1'b1; tx_data = 8'h96;
    @(negedge clk);
    tx_data = 8'h69;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("t5_count", fifo_count, 3'd1);
    check_bits(mk_frame(8'h96), 0, 2*CPB, "t5_frame1a");
    ena = 1'b0;
    check_bits(mk_frame(8'h96), 2*CPB, NB*CPB, "t5_frame1b");
    chk("t5_ready_off", tx_ready, 1'b0);
    chk("t5_busy_held", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t5_hold_tx", tx, 1'b1);
      @(negedge clk);
    end
    chk("t5_count_kept", fifo_count, 3'd1);
    ena = 1'b1;
    @(negedge clk);
    chk("t5_count_pop", fifo_count, 3'd0);
    check_bits(mk_frame(8'h69), 0, NB*CPB, "t5_frame2");
    wait_idle(4*CPB, "t5_idle");

`ifdef SUMMER_UART_PARITY_EN
    // 6: parity bit values
    tx_valid = 1'b1; tx_data = 8'h07;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    check_bits(11'b11000001110, 0, NB*CPB, "t6_frame07");
    wait_idle(4*CPB, "t6_idle07");
    tx_valid = 1'b1; tx_data = 8'h03;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    check_bits(11'b10000000110, 0, NB*CPB, "t6_frame03");
    wait_idle(4*CPB, "t6_idle03");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
